// File: rtl/gpr_arb_pkg.sv
// Shared types and constants for the GPR writeback arbiter.
// Used by gpr_arb_fifo and gpr_wb_arbiter.
package gpr_arb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_MDU
    } grant_e;

endpackage

// File: rtl/gpr_arb_fifo.sv
// Synchronous DEPTH-entry FIFO of pending MDU writebacks.
// A push and a pop in the same cycle are accepted even when full.
module gpr_arb_fifo
    import gpr_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the pop frees this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between W-stage writeback and buffered MDU results,
// tracks in-flight MDU destinations for hazards. Optional trace output: define WB_TRACE_EN.
module gpr_wb_arbiter
    import gpr_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              mdu_issue,
    input  logic [REG_AW-1:0] mdu_issue_addr,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_AW-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic [DATA_W-1:0] mdu_pc,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic              hazard,
    output logic              pipe_stall,
    output logic              gpr_we,
    output logic [REG_AW-1:0] gpr_a3,
    output logic [DATA_W-1:0] gpr_wd,
    output logic [DATA_W-1:0] gpr_pc
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t              head;
    wb_entry_t              sel;
    grant_e                 grant;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   we_next;
    logic                   stall_next;
    logic [CW-1:0]          starve_cnt;
    logic [2**REG_AW-1:0]   busy;
    logic [2**REG_AW-1:0]   busy_next;

    assign mdu_ready = !fifo_full;
    assign push      = mdu_valid && mdu_ready;

    gpr_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ('{addr: mdu_addr, data: mdu_data, pc: mdu_pc}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A forced bubble always hands the slot to the FIFO head.
    always_comb begin
        grant = GRANT_NONE;
        sel   = head;
        pop   = 1'b0;
        if (wb_valid && !pipe_stall) begin
            grant = GRANT_WB;
            sel   = '{addr: wb_addr, data: wb_data, pc: wb_pc};
        end else if (!fifo_empty) begin
            grant = GRANT_MDU;
            pop   = 1'b1;
        end
    end

    assign we_next    = (grant != GRANT_NONE) && (sel.addr != REG_ZERO);
    assign stall_next = !fifo_empty && !pop && (starve_cnt == CW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= stall_next;
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Issue is applied after the clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (pop && head.addr != REG_ZERO)
            busy_next[head.addr] = 1'b0;
        if (mdu_issue && mdu_issue_addr != REG_ZERO)
            busy_next[mdu_issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    assign hazard = busy[rs_addr] | busy[rt_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_we <= 1'b0;
            gpr_a3 <= '0;
            gpr_wd <= '0;
            gpr_pc <= '0;
        end else begin
            gpr_we <= we_next;
            if (grant != GRANT_NONE) begin
                gpr_a3 <= sel.addr;
                gpr_wd <= sel.data;
                gpr_pc <= sel.pc;
            end
        end
    end

    a_no_wb_in_stall: assert property (@(posedge clk) disable iff (reset) !(pipe_stall && wb_valid))
        else $error("wb_valid asserted while pipe_stall is high");

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && we_next)
            $display("%d@%h: $%d <= %h", $time, sel.pc, sel.addr, sel.data);
    end
`else
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: scoreboard of expected GPR writes plus directed checks.
module tb_gpr_wb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        hazard;
    logic        pipe_stall;
    logic        gpr_we;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wd;
    logic [31:0] gpr_pc;

    int total = 0;
    int bad   = 0;

    ent_t mq[$];
    logic exp_we = 1'b0;
    ent_t exp_e;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_pc          (wb_pc),
        .mdu_issue      (mdu_issue),
        .mdu_issue_addr (mdu_issue_addr),
        .mdu_valid      (mdu_valid),
        .mdu_ready      (mdu_ready),
        .mdu_addr       (mdu_addr),
        .mdu_data       (mdu_data),
        .mdu_pc         (mdu_pc),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .hazard         (hazard),
        .pipe_stall     (pipe_stall),
        .gpr_we         (gpr_we),
        .gpr_a3         (gpr_a3),
        .gpr_wd         (gpr_wd),
        .gpr_pc         (gpr_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: W-stage wins, else oldest queued MDU result; push only when not full.
    task automatic model_edge();
        bit do_pop;
        bit full;
        full   = (mq.size() >= DEPTH);
        do_pop = !wb_valid && (mq.size() != 0);
        if (wb_valid) begin
            exp_we = (wb_addr != 5'd0);
            exp_e  = '{a: wb_addr, d: wb_data, pc: wb_pc};
        end else if (do_pop) begin
            exp_e  = mq.pop_front();
            exp_we = (exp_e.a != 5'd0);
        end else begin
            exp_we = 1'b0;
        end
        if (mdu_valid && !full)
            mq.push_back('{a: mdu_addr, d: mdu_data, pc: mdu_pc});
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            exp_we = 1'b0;
        end else begin
            model_edge();
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("wr_we", gpr_we, exp_we);
        if (exp_we) begin
            check("wr_a3", gpr_a3, exp_e.a);
            check("wr_wd", gpr_wd, exp_e.d);
            check("wr_pc", gpr_pc, exp_e.pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
        mdu_issue = 0; mdu_issue_addr = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0; mdu_pc = 0;
        rs_addr = 0; rt_addr = 0;
        @(negedge clk);
        step();
        step();
        check("rst_we", gpr_we, 0);
        check("rst_a3", gpr_a3, 0);
        check("rst_stall", pipe_stall, 0);
        check("rst_ready", mdu_ready, 1);
        check("rst_hazard", hazard, 0);
        reset = 1'b0;
        step();

        // W-stage only, then an idle cycle holds the last address
        wb_valid = 1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF; wb_pc = 32'h0000_1000;
        step();
        wb_valid = 0;
        check("t1_we", gpr_we, 1);
        check("t1_a3", gpr_a3, 8);
        check("t1_wd", gpr_wd, 32'hDEADBEEF);
        step();
        check("t1_idle_we", gpr_we, 0);
        check("t1_hold_a3", gpr_a3, 8);

        // MDU drain with hazard tracking
        mdu_issue = 1; mdu_issue_addr = 5'd9; rs_addr = 5'd9;
        step();
        mdu_issue = 0;
        check("t2_haz_issue", hazard, 1);
        mdu_valid = 1; mdu_addr = 5'd9; mdu_data = 32'h0000_0010; mdu_pc = 32'h0000_2000;
        step();
        mdu_valid = 0;
        check("t2_haz_queued", hazard, 1);
        check("t2_no_bypass", gpr_we, 0);
        step();
        check("t2_we", gpr_we, 1);
        check("t2_a3", gpr_a3, 9);
        check("t2_haz_clear", hazard, 0);

        // Starvation under continuous W-stage traffic
        wb_valid = 1; wb_addr = 5'd1; wb_data = 32'h1111_0000; wb_pc = 32'h3000;
        mdu_valid = 1; mdu_addr = 5'd12; mdu_data = 32'hCAFE_0012; mdu_pc = 32'h0000_3100;
        step();
        mdu_valid = 0;
        for (int j = 1; j <= 9; j++) begin
            check("t3_stall", pipe_stall, 32'(j == 9));
            wb_valid = !pipe_stall;
            wb_addr  = 5'(10 + j);
            wb_data  = 32'h1111_0000 + 32'(j);
            wb_pc    = 32'h3000 + 32'(4 * j);
            step();
        end
        check("t3_mdu_we", gpr_we, 1);
        check("t3_mdu_a3", gpr_a3, 12);
        check("t3_stall_end", pipe_stall, 0);
        wb_valid = 0;
        step();

        // Fill the FIFO, observe back-pressure and draining order
        for (int i = 0; i < DEPTH; i++) begin
            wb_valid = !pipe_stall; wb_addr = 5'd20; wb_data = 32'(i); wb_pc = 32'h4000 + 32'(4 * i);
            mdu_valid = 1; mdu_addr = 5'(21 + i); mdu_data = 32'hA0 + 32'(i); mdu_pc = 32'h4100 + 32'(4 * i);
            step();
        end
        check("t4_full", mdu_ready, 0);
        mdu_addr = 5'd25; mdu_data = 32'hA4; mdu_pc = 32'h4110;
        wb_valid = !pipe_stall;
        step();
        check("t4_hold", mdu_ready, 0);
        wb_valid = 0;
        step();
        check("t4_ready", mdu_ready, 1);
        wb_valid = !pipe_stall;
        step();
        check("t4_refull", mdu_ready, 0);
        mdu_valid = 0; wb_valid = 0;
        repeat (5) step();
        check("t4_drained", mdu_ready, 1);

        // Same-cycle issue and grant of $5, then a result to $0
        mdu_issue = 1; mdu_issue_addr = 5'd5; rs_addr = 5'd5; rt_addr = 5'd0;
        step();
        mdu_issue = 0;
        mdu_valid = 1; mdu_addr = 5'd5; mdu_data = 32'h5555; mdu_pc = 32'h5000;
        step();
        mdu_valid = 0;
        mdu_issue = 1; mdu_issue_addr = 5'd5;
        step();
        mdu_issue = 0;
        check("t5_grant5", gpr_a3, 5);
        check("t5_setwins", hazard, 1);
        mdu_valid = 1; mdu_addr = 5'd0; mdu_data = 32'h0BAD; mdu_pc = 32'h5100;
        step();
        mdu_valid = 0;
        step();
        check("t5_zero_we", gpr_we, 0);
        rs_addr = 5'd0; rt_addr = 5'd5;
        #1 check("t5_haz_rt", hazard, 1);
        rt_addr = 5'd0;
        #1 check("t5_haz_zero", hazard, 0);

        // Reset in the middle of queued work
        mdu_issue = 1; mdu_issue_addr = 5'd3;
        step();
        mdu_issue_addr = 5'd4;
        step();
        mdu_issue = 0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = !pipe_stall; wb_addr = 5'd2; wb_data = 32'h6000 + 32'(i); wb_pc = 32'h6000;
            mdu_valid = 1; mdu_addr = 5'(3 + i); mdu_data = 32'h6100 + 32'(i); mdu_pc = 32'h6100;
            step();
        end
        mdu_valid = 0; wb_valid = 0;
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1 check("t6_haz_pre", hazard, 1);
        reset = 1;
        step();
        reset = 0;
        check("t6_we", gpr_we, 0);
        check("t6_a3", gpr_a3, 0);
        check("t6_wd", gpr_wd, 0);
        check("t6_pc", gpr_pc, 0);
        check("t6_stall", pipe_stall, 0);
        check("t6_ready", mdu_ready, 1);
        check("t6_hazard", hazard, 0);
        step();
        step();
        wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h7777_7777; wb_pc = 32'h7000;
        step();
        wb_valid = 0;
        check("t6_after_we", gpr_we, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
